// File: rtl/spawn_scheduler.sv
// spawn_scheduler: LFSR-driven countdown arming and platform-spawn request generator.
// Optional SPAWN_DIFFICULTY_EN narrows the random gap as spawn_count grows.
module spawn_scheduler #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  MIN_GAP   = 8'd16,
  parameter logic [9:0]  X_MAX     = 10'd600
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic        cd_done,
  output logic        cd_load,
  output logic        cd_enable,
  output logic [7:0]  cd_seed,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic [9:0]  spawn_x,
  output logic [1:0]  spawn_type,
  output logic [15:0] spawn_count
);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT, EMIT} state_t;
  localparam logic [15:0] SEED0 = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  state_t state, state_nx;
  logic [15:0] lfsr, count_nx;
  logic [5:0] off;
  logic [8:0] gap;
  logic [9:0] raw, x_nx;
  logic hs;
  assign hs = spawn_valid & spawn_ready;
  assign count_nx = spawn_count + 16'(hs);
`ifdef SPAWN_DIFFICULTY_EN
  logic [1:0] lvl;
  assign lvl = (|count_nx[15:6]) ? 2'd3 : count_nx[5:4];
  assign off = lfsr[5:0] >> lvl;
`else
  assign off = lfsr[5:0];
`endif
  assign gap = {1'b0, MIN_GAP} + {3'b0, off};
  assign raw = lfsr[15:6];
  assign x_nx = (raw >= X_MAX) ? raw - X_MAX : raw;
  assign cd_load = state == LOAD;
  assign cd_enable = state == WAIT;
  assign spawn_valid = state == EMIT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = enable ? LOAD : IDLE;
      LOAD: state_nx = ARM;
      ARM:  state_nx = WAIT;
      WAIT: state_nx = !enable ? IDLE : cd_done ? EMIT : WAIT;
      EMIT: state_nx = !hs ? EMIT : enable ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      lfsr <= SEED0;
      cd_seed <= '0;
      spawn_x <= '0;
      spawn_type <= '0;
      spawn_count <= '0;
    end else begin
      state <= state_nx;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
      spawn_count <= count_nx;
      if (state_nx == LOAD) cd_seed <= gap[8] ? 8'hFF : gap[7:0];
      if (state == WAIT && state_nx == EMIT) begin
        spawn_x <= x_nx;
        spawn_type <= lfsr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: scoreboard bench for spawn_scheduler with a reference LFSR and countdown model.
module tb_spawn_scheduler;
  localparam logic [9:0] XM = 10'd512;
  logic Clk = 0, Reset = 1, enable = 0, cd_done = 0, spawn_ready = 0;
  logic cd_load, cd_enable, spawn_valid;
  logic [7:0] cd_seed;
  logic [9:0] spawn_x;
  logic [1:0] spawn_type;
  logic [15:0] spawn_count;
  logic [15:0] m, m_prev;
  logic [11:0] q[$];
  int tests = 0, fails = 0, cnt = 0;

  spawn_scheduler #(.LFSR_SEED(16'h0000), .MIN_GAP(8'd16), .X_MAX(XM)) dut (
    .Clk(Clk), .Reset(Reset), .enable(enable), .cd_done(cd_done),
    .cd_load(cd_load), .cd_enable(cd_enable), .cd_seed(cd_seed),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_type(spawn_type), .spawn_count(spawn_count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or posedge Reset)
    if (Reset) begin
      m <= 16'h0001;
      m_prev <= 16'h0001;
    end else begin
      m_prev <= m;
      m <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seed(input logic [15:0] l, input int c);
    int o;
    o = int'(l[5:0]);
`ifdef SPAWN_DIFFICULTY_EN
    o = o >> (((c >> 4) > 3) ? 3 : (c >> 4));
`else
    o = o + 0 * c;
`endif
    return (16 + o > 255) ? 8'hFF : 8'(16 + o);
  endfunction

  task automatic wait_load();
    int i = 0;
    while (!cd_load && i < 50) begin
      @(negedge Clk);
      i++;
    end
    check("load_seen", {31'b0, cd_load}, 1);
    if (cd_load) check("seed", {24'b0, cd_seed}, {24'b0, exp_seed(m_prev, cnt)});
`ifdef SPAWN_DIFFICULTY_EN
    if (cd_load && cnt >= 48) check("seed_lvl3", {31'b0, cd_seed <= 8'd23}, 1);
`endif
  endtask

  task automatic arm_to_wait();
    wait_load();
    repeat (20) @(negedge Clk);
    check("cd_enable_wait", {31'b0, cd_enable}, 1);
  endtask

  task automatic go_emit();
    logic [9:0] raw;
    logic [11:0] e;
    arm_to_wait();
    raw = m[15:6];
    q.push_back({(raw >= XM) ? raw - XM : raw, m[1:0]});
    cd_done = 1;
    @(negedge Clk);
    cd_done = 0;
    check("valid_rise", {31'b0, spawn_valid}, 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("spawn_x", {22'b0, spawn_x}, {22'b0, e[11:2]});
      check("spawn_type", {30'b0, spawn_type}, {30'b0, e[1:0]});
    end
    check("x_range", {31'b0, spawn_x < XM}, 1);
  endtask

  task automatic accept();
    spawn_ready = 1;
    @(negedge Clk);
    spawn_ready = 0;
    cnt++;
    check("count", {16'b0, spawn_count}, {16'b0, cnt[15:0]});
    check("valid_fall", {31'b0, spawn_valid}, 0);
    check("rearm", {31'b0, cd_load}, {31'b0, enable});
  endtask

  initial begin
    logic [9:0] x0;
    logic [1:0] t0;
    logic seen;
    #12;
    check("rst_load", {31'b0, cd_load}, 0);
    check("rst_cden", {31'b0, cd_enable}, 0);
    check("rst_valid", {31'b0, spawn_valid}, 0);
    check("rst_count", {16'b0, spawn_count}, 0);
    check("rst_seed", {24'b0, cd_seed}, 0);
    @(negedge Clk);
    Reset = 0;
    enable = 1;
    @(negedge Clk);
    check("first_load", {31'b0, cd_load}, 1);
    check("first_seed", {24'b0, cd_seed}, 17);
    go_emit();
    x0 = spawn_x;
    t0 = spawn_type;
    repeat (5) begin
      @(negedge Clk);
      check("hold_valid", {31'b0, spawn_valid}, 1);
      check("hold_x", {22'b0, spawn_x}, {22'b0, x0});
      check("hold_type", {30'b0, spawn_type}, {30'b0, t0});
      check("hold_count", {16'b0, spawn_count}, 0);
    end
    accept();
    arm_to_wait();
    enable = 0;
    cd_done = 1;
    @(negedge Clk);
    cd_done = 0;
    check("drop_cden", {31'b0, cd_enable}, 0);
    check("drop_valid", {31'b0, spawn_valid}, 0);
    seen = 0;
    repeat (5) begin
      @(negedge Clk);
      seen |= spawn_valid | cd_load;
    end
    check("drop_idle", {31'b0, seen}, 0);
    enable = 1;
    @(negedge Clk);
    go_emit();
    Reset = 1;
    #1;
    check("arst_valid", {31'b0, spawn_valid}, 0);
    check("arst_count", {16'b0, spawn_count}, 0);
    check("arst_load", {31'b0, cd_load}, 0);
    q.delete();
    cnt = 0;
    @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    check("reseed_load", {31'b0, cd_load}, 1);
    check("reseed_seed", {24'b0, cd_seed}, 17);
    repeat (100) begin
      go_emit();
      accept();
    end
    enable = 0;
    repeat (3) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Sits directly upstream and downstream of the countdown timer.
- Picks a pseudo-random gap, loads it into the countdown as its seed, and waits for the countdown's done.
- Then emits one platform-spawn request (x position and type) to the platform manager over a valid/ready handshake.
- Re-arms automatically while enabled, giving the game a randomised stream of platform spawns.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is forced to 16'h0001.
- MIN_GAP, 8'd16, minimum countdown seed.
- X_MAX, 10'd600, exclusive upper bound of spawn_x; legal range 512..1023.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; scheduler arms only while high.
- cd_done  in  1  done from countdown.
- cd_load  out  1  one-cycle pulse driving the countdown's Reset, loading cd_seed.
- cd_enable  out  1  countdown enable; high in WAIT only.
- cd_seed  out  8  seed presented to countdown; stable while cd_load is high.
- spawn_valid  out  1  spawn request pending.
- spawn_ready  in  1  consumer accepts the request.
- spawn_x  out  10  platform x position, 0..X_MAX-1.
- spawn_type  out  2  platform type code.
- spawn_count  out  16  spawns accepted since reset; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async): state=IDLE; lfsr=LFSR_SEED (or 1 if 0); all outputs 0.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. Advances every clock regardless of state; never reaches 0.
- Gap: cd_seed = MIN_GAP + {2'b0, lfsr[5:0]}, computed in 9 bits, saturated to 8'hFF. Latched on entry to LOAD.
- Position: raw = lfsr[15:6]; spawn_x = (raw >= X_MAX) ? raw - X_MAX : raw. Single subtraction, valid because X_MAX >= 512.
- Type: spawn_type = lfsr[1:0]. spawn_x and spawn_type are latched on the WAIT->EMIT transition.
- States: IDLE, LOAD, ARM, WAIT, EMIT.
- IDLE: all strobes low. enable=1 -> LOAD next cycle.
- LOAD: cd_load=1 for exactly one cycle -> ARM.
- ARM: one dead cycle; cd_done is ignored here because the countdown clears done on load -> WAIT.
- WAIT: cd_enable=1.
  - cd_done=1 -> EMIT.
  - enable=0 -> IDLE; the wait is abandoned and nothing is emitted.
  - enable drop takes priority over cd_done in the same cycle.
- EMIT: spawn_valid=1; spawn_x and spawn_type held stable.
  - Valid is never withdrawn, even if enable drops.
  - On spawn_valid & spawn_ready: spawn_count++, then go to LOAD if enable=1, else IDLE.
  - spawn_valid falls the cycle after the handshake.
- Latency: enable rise -> cd_load in 1 cycle; cd_done -> spawn_valid in 1 cycle. Handshake -> next cd_load in 1 cycle (back-to-back re-arm).
- Reset asserted mid-operation: immediate return to the reset state; any pending spawn is dropped.

Optional Feature:
SPAWN_DIFFICULTY_EN
- Defined: adds a difficulty level to the gap calculation.
  - lvl = min(spawn_count[15:4], 3).
  - Gap offset becomes lfsr[5:0] >> lvl, so the random spread shrinks every 16 spawns, bottoming out at level 3.
  - Level is sampled at entry to LOAD.
- Not defined: offset is always lfsr[5:0]; no extra logic.

Test Plan:
- Reset with LFSR_SEED=0, then enable=1 -> lfsr=16'h0001. cd_load pulses once in cycle 1, with cd_seed in 16..79.
- Countdown model raises cd_done 20 cycles after load -> spawn_valid high next cycle. spawn_x<600 and spawn_count goes 0->1 on the handshake.
- Hold spawn_ready=0 for 5 cycles in EMIT -> spawn_valid, spawn_x and spawn_type remain constant and spawn_count does not increment.
- Drop enable in WAIT with cd_done rising the same cycle -> IDLE, no spawn_valid, cd_enable=0.
- Assert Reset during EMIT -> spawn_valid=0, spawn_count=0, cd_load=0 immediately (asynchronous), LFSR back to LFSR_SEED.
- Run 100 spawns with X_MAX=512 -> every spawn_x<512. With SPAWN_DIFFICULTY_EN defined, every cd_seed after spawn 48 is in 16..23.
